// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: entry kinds,
// BTB entry layout and 2-bit counter encodings.
package branch_predictor_pkg;

  localparam int TAG_W_MAX = 30;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_RSVD   = 2'd3
  } bp_kind_t;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Tag is held at maximum width; unused upper bits are always zero.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    bp_kind_t             kind;
    logic                 is_ret;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case ({taken, ctr})
      3'b1_11: res = CTR_ST;
      3'b0_00: res = CTR_SNT;
      3'b1_00, 3'b1_01, 3'b1_10: res = ctr + 2'd1;
      3'b0_01, 3'b0_10, 3'b0_11: res = ctr - 2'd1;
      default: res = CTR_RESET;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] ptr_r;
  logic [PW:0]   cnt_r;
  logic [PW-1:0] top_idx_s;

  assign top_idx_s = ptr_r - PW'(1);
  assign top       = mem_r[top_idx_s];
  assign empty     = (cnt_r == (PW+1)'(0));
  assign full      = (cnt_r == FULL_CNT);

  // Stack pointer, occupancy and storage; call+ret on a non-empty stack rewrites the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
      cnt_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (push && pop && !empty) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
      ptr_r        <= ptr_r + PW'(1);
      if (!full) begin
        cnt_r <= cnt_r + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_r <= ptr_r - PW'(1);
      cnt_r <= cnt_r - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped flop-based BTB with 2-bit counters plus a return-address
// stack; combinational lookup, updates committed on the clock edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic [1:0]  upd_kind,
  input  logic        upd_is_call,
  input  logic        upd_is_ret
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [31:0] TAG_MASK = (32'd1 << TAG_BITS) - 32'd1;

  btb_entry_t btb_r [ENTRIES];

  logic [IDX_W-1:0]     lk_idx_s, up_idx_s;
  logic [TAG_W_MAX-1:0] lk_tag_s, up_tag_s;
  btb_entry_t           lk_entry_s, up_entry_s, new_entry_s;
  logic                 lk_match_s, up_match_s, upd_ok_s, btb_we_s;
  logic                 ras_push_s, ras_pop_s, ras_empty_s, ras_full_s;
  logic [31:0]          ras_top_s, lk_seq_s;
  logic                 unused_s;

  assign lk_idx_s   = lookup_pc[IDX_W+1:2];
  assign up_idx_s   = upd_pc[IDX_W+1:2];
  assign lk_tag_s   = TAG_W_MAX'((lookup_pc >> (IDX_W + 2)) & TAG_MASK);
  assign up_tag_s   = TAG_W_MAX'((upd_pc >> (IDX_W + 2)) & TAG_MASK);
  assign lk_entry_s = btb_r[lk_idx_s];
  assign up_entry_s = btb_r[up_idx_s];
  assign lk_match_s = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
  assign up_match_s = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
  assign lk_seq_s   = lookup_pc + 32'd4;
  assign unused_s   = ^{lookup_pc[1:0], upd_pc[1:0], ras_full_s};

  // Reserved kind is a no-op for both BTB and RAS.
  assign upd_ok_s   = upd_valid && (upd_kind != 2'd3) && !reset;
  assign ras_push_s = upd_ok_s && upd_is_call;
  assign ras_pop_s  = upd_ok_s && upd_is_ret;

  // Prediction from the current (pre-update) BTB contents.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lk_seq_s;
    if (!reset && lk_match_s) begin
      pred_hit = 1'b1;
      case (lk_entry_s.kind)
        KIND_BRANCH: begin
          pred_taken  = lk_entry_s.ctr[1];
          pred_target = lk_entry_s.ctr[1] ? lk_entry_s.target : lk_seq_s;
        end
        KIND_JAL: begin
          pred_taken  = 1'b1;
          pred_target = lk_entry_s.target;
        end
        KIND_JALR: begin
          pred_taken  = 1'b1;
          pred_target = (lk_entry_s.is_ret && !ras_empty_s) ? ras_top_s : lk_entry_s.target;
        end
        default: begin
          pred_hit    = 1'b0;
          pred_taken  = 1'b0;
          pred_target = lk_seq_s;
        end
      endcase
    end else begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = lk_seq_s;
    end
  end

  // Entry to write; a not-taken branch with no matching entry never allocates.
  always_comb begin
    new_entry_s        = up_entry_s;
    btb_we_s           = 1'b0;
    new_entry_s.valid  = 1'b1;
    new_entry_s.tag    = up_tag_s;
    new_entry_s.kind   = bp_kind_t'(upd_kind);
    new_entry_s.is_ret = upd_is_ret;
    if (up_match_s) begin
      btb_we_s           = upd_ok_s;
      new_entry_s.ctr    = ctr_next(up_entry_s.ctr, upd_taken);
      new_entry_s.target = upd_taken ? upd_target : up_entry_s.target;
    end else begin
      btb_we_s           = upd_ok_s && (upd_taken || (upd_kind != 2'd0));
      new_entry_s.ctr    = upd_taken ? CTR_WT : CTR_WNT;
      new_entry_s.target = upd_target;
    end
  end

  // BTB storage: full clear on reset, single-entry write otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_r[i] <= '{valid: 1'b0, tag: '0, kind: KIND_BRANCH, is_ret: 1'b0,
                      target: 32'd0, ctr: CTR_RESET};
      end
    end else if (btb_we_s) begin
      btb_r[up_idx_s] <= new_entry_s;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (upd_pc + 32'd4),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_kind;
  logic        upd_is_call;
  logic        upd_is_ret;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] K_BR = 2'd0, K_JAL = 2'd1, K_JALR = 2'd2, K_RSVD = 2'd3;

  branch_predictor #(.ENTRIES(16), .TAG_BITS(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_kind(upd_kind),
    .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic [1:0] kind, input logic call, input logic ret);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    upd_kind = kind; upd_is_call = call; upd_is_ret = ret;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic [1:0] kind, input logic call, input logic ret);
    set_upd(pc, tgt, tk, kind, call, ret);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0;
    upd_taken = 1'b0; upd_kind = K_BR; upd_is_call = 1'b0; upd_is_ret = 1'b0;
    lookup_pc = 32'd0;
    tick(); tick();
    look(32'h100);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
      errors++; $display("FAIL reset_during: got hit=%b tk=%b tgt=%h want 0 0 00000104", pred_hit, pred_taken, pred_target);
    end
    reset = 1'b0;
    tick();
    look(32'h100);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
      errors++; $display("FAIL reset_after: got hit=%b tk=%b tgt=%h want 0 0 00000104", pred_hit, pred_taken, pred_target);
    end
    look(32'hFFFF_FFFC);
    checks++;
    if ({pred_hit, pred_target} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL pc_wrap: got hit=%b tgt=%h want 0 00000000", pred_hit, pred_target);
    end
  endtask

  task automatic test_branch_counter();
    do_upd(32'h200, 32'h180, 1'b1, K_BR, 1'b0, 1'b0);
    look(32'h200);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h180}) begin
      errors++; $display("FAIL br_alloc: got hit=%b tk=%b tgt=%h want 1 1 00000180", pred_hit, pred_taken, pred_target);
    end
    do_upd(32'h200, 32'h180, 1'b1, K_BR, 1'b0, 1'b0);
    do_upd(32'h200, 32'h180, 1'b1, K_BR, 1'b0, 1'b0);
    do_upd(32'h200, 32'h180, 1'b0, K_BR, 1'b0, 1'b0);
    look(32'h200);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h180}) begin
      errors++; $display("FAIL br_sat_10: got hit=%b tk=%b tgt=%h want 1 1 00000180", pred_hit, pred_taken, pred_target);
    end
    do_upd(32'h200, 32'h999, 1'b0, K_BR, 1'b0, 1'b0);
    look(32'h200);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h204}) begin
      errors++; $display("FAIL br_01: got hit=%b tk=%b tgt=%h want 1 0 00000204", pred_hit, pred_taken, pred_target);
    end
    do_upd(32'h200, 32'h999, 1'b0, K_BR, 1'b0, 1'b0);
    do_upd(32'h200, 32'h999, 1'b0, K_BR, 1'b0, 1'b0);
    do_upd(32'h200, 32'h180, 1'b1, K_BR, 1'b0, 1'b0);
    look(32'h200);
    checks++;
    if ({pred_hit, pred_taken} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL br_floor: got hit=%b tk=%b want 1 0", pred_hit, pred_taken);
    end
    do_upd(32'h200, 32'h180, 1'b1, K_BR, 1'b0, 1'b0);
    look(32'h200);
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h180}) begin
      errors++; $display("FAIL br_target_kept: got tk=%b tgt=%h want 1 00000180", pred_taken, pred_target);
    end
  endtask

  task automatic test_no_alloc();
    do_upd(32'h700, 32'h7a0, 1'b0, K_BR, 1'b0, 1'b0);
    look(32'h700);
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL nt_no_alloc: got hit=%b want 0", pred_hit);
    end
    do_upd(32'h744, 32'h800, 1'b1, K_RSVD, 1'b0, 1'b0);
    look(32'h744);
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL kind3_ignored: got hit=%b want 0", pred_hit);
    end
    set_upd(32'h748, 32'h800, 1'b1, K_JAL, 1'b0, 1'b0);
    upd_valid = 1'b0;
    tick();
    look(32'h748);
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL valid_low: got hit=%b want 0", pred_hit);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_upd(32'h300, 32'h400, 1'b1, K_JAL, 1'b1, 1'b0);
    do_upd(32'h410, 32'h304, 1'b1, K_JALR, 1'b0, 1'b1);
    look(32'h410);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h304}) begin
      errors++; $display("FAIL ret_0x304: got hit=%b tk=%b tgt=%h want 1 1 00000304", pred_hit, pred_taken, pred_target);
    end
    do_upd(32'h320, 32'h400, 1'b1, K_JAL, 1'b1, 1'b0);
    look(32'h410);
    checks++;
    if (pred_target !== 32'h324) begin
      errors++; $display("FAIL ret_from_ras: got tgt=%h want 00000324", pred_target);
    end
    look(32'h300);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h400}) begin
      errors++; $display("FAIL jal_hit: got hit=%b tk=%b tgt=%h want 1 1 00000400", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_top [4];
    exp_top[0] = 32'h54; exp_top[1] = 32'h44; exp_top[2] = 32'h34; exp_top[3] = 32'h24;
    do_reset();
    do_upd(32'h604, 32'h700, 1'b1, K_JALR, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      do_upd(32'h10 * i, 32'h900, 1'b1, K_JAL, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      look(32'h604);
      checks++;
      if (pred_target !== exp_top[i]) begin
        errors++; $display("FAIL ras_pop%0d: got tgt=%h want %h", i, pred_target, exp_top[i]);
      end
      do_upd(32'h604, 32'h700, 1'b1, K_JALR, 1'b0, 1'b1);
    end
    look(32'h604);
    checks++;
    if (pred_target !== 32'h700) begin
      errors++; $display("FAIL ras_empty: got tgt=%h want 00000700", pred_target);
    end
    do_upd(32'h604, 32'h700, 1'b1, K_JALR, 1'b0, 1'b1);
    do_upd(32'h60, 32'h900, 1'b1, K_JAL, 1'b1, 1'b0);
    look(32'h604);
    checks++;
    if (pred_target !== 32'h64) begin
      errors++; $display("FAIL ras_underflow: got tgt=%h want 00000064", pred_target);
    end
    do_upd(32'h80, 32'h900, 1'b1, K_JALR, 1'b1, 1'b1);
    look(32'h604);
    checks++;
    if (pred_target !== 32'h84) begin
      errors++; $display("FAIL ras_callret: got tgt=%h want 00000084", pred_target);
    end
    do_upd(32'h604, 32'h700, 1'b1, K_JALR, 1'b0, 1'b1);
    look(32'h604);
    checks++;
    if (pred_target !== 32'h700) begin
      errors++; $display("FAIL ras_callret_depth: got tgt=%h want 00000700", pred_target);
    end
  endtask

  task automatic test_alias();
    do_reset();
    do_upd(32'h1000, 32'h1100, 1'b1, K_JAL, 1'b0, 1'b0);
    do_upd(32'h1040, 32'h1200, 1'b1, K_JAL, 1'b0, 1'b0);
    look(32'h1000);
    checks++;
    if ({pred_hit, pred_target} !== {1'b0, 32'h1004}) begin
      errors++; $display("FAIL alias_old: got hit=%b tgt=%h want 0 00001004", pred_hit, pred_target);
    end
    look(32'h1040);
    checks++;
    if ({pred_hit, pred_target} !== {1'b1, 32'h1200}) begin
      errors++; $display("FAIL alias_new: got hit=%b tgt=%h want 1 00001200", pred_hit, pred_target);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_upd(32'h500, 32'h520, 1'b1, K_JAL, 1'b0, 1'b0);
    look(32'h500);
    checks++;
    if ({pred_hit, pred_target} !== {1'b0, 32'h504}) begin
      errors++; $display("FAIL same_cycle: got hit=%b tgt=%h want 0 00000504", pred_hit, pred_target);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if ({pred_hit, pred_target} !== {1'b1, 32'h520}) begin
      errors++; $display("FAIL next_cycle: got hit=%b tgt=%h want 1 00000520", pred_hit, pred_target);
    end
  endtask

  task automatic test_reset_mid();
    do_upd(32'h240, 32'h280, 1'b1, K_JAL, 1'b0, 1'b0);
    reset = 1'b1;
    set_upd(32'h2c0, 32'h2e0, 1'b1, K_JAL, 1'b0, 1'b0);
    look(32'h240);
    checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h244}) begin
      errors++; $display("FAIL reset_mask: got hit=%b tk=%b tgt=%h want 0 0 00000244", pred_hit, pred_taken, pred_target);
    end
    tick();
    reset = 1'b0;
    upd_valid = 1'b0;
    look(32'h240);
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL reset_clears: got hit=%b want 0", pred_hit);
    end
    look(32'h2c0);
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL reset_drops_upd: got hit=%b want 0", pred_hit);
    end
  endtask

  initial begin
    test_reset();
    test_branch_counter();
    test_no_alloc();
    test_call_ret();
    test_ras_overflow();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
